// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD field bank: command encodings, default
// per-field limits and symbolic field indices.
package bcd_pkg;

    typedef enum logic [1:0] {
        OP_LOAD_BYTE  = 2'b00,
        OP_LOAD_UNITS = 2'b01,
        OP_INC        = 2'b10,
        OP_DEC        = 2'b11
    } bcd_op_e;

    // Field 0 sits in the least significant byte.
    localparam logic [71:0] DEF_FIELD_MAX =
        {8'h59, 8'h59, 8'h23, 8'h99, 8'h31, 8'h12, 8'h59, 8'h59, 8'h23};
    localparam logic [71:0] DEF_FIELD_MIN =
        {8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00};

    localparam int F_HOUR     = 0;
    localparam int F_MIN      = 1;
    localparam int F_SEC      = 2;
    localparam int F_MONTH    = 3;
    localparam int F_DAY      = 4;
    localparam int F_YEAR     = 5;
    localparam int F_HOUR_TI  = 6;
    localparam int F_MIN_TI   = 7;
    localparam int F_SEC_TI   = 8;

endpackage

// File: rtl/bcd_step.sv
// Two-digit BCD increment/decrement with wrap between the field limits.
module bcd_step (
    input  logic [7:0] val,
    input  logic [7:0] lo,
    input  logic [7:0] hi,
    input  logic       dec,
    output logic [7:0] res
);

    // Valid BCD orders the same as binary, so limits compare directly.
    always_comb begin
        res = val;
        if (!dec) begin
            if (val >= hi)
                res = lo;
            else if (val[3:0] >= 4'd9)
                res = {val[7:4] + 4'd1, 4'h0};
            else
                res = {val[7:4], val[3:0] + 4'd1};
        end else begin
            if (val <= lo)
                res = hi;
            else if (val[3:0] == 4'd0)
                res = {val[7:4] - 4'd1, 4'h9};
            else
                res = {val[7:4], val[3:0] - 4'd1};
        end
    end

endmodule

// File: rtl/bcd_field_bank.sv
// Bank of two-digit BCD fields (clock, calendar, timer) updated by
// load / increment / decrement commands with range checking.
//
// state | meaning
// IDLE  | ready; cmd_valid latches op/idx/data
// EXEC  | applies the latched command on the next edge, pulses cmd_done
module bcd_field_bank
    import bcd_pkg::*;
#(
    parameter int                    N_FIELDS  = 9,
    parameter logic [N_FIELDS*8-1:0] FIELD_MAX = DEF_FIELD_MAX,
    parameter logic [N_FIELDS*8-1:0] FIELD_MIN = DEF_FIELD_MIN,
    localparam int                   IDX_W     = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [IDX_W-1:0]        cmd_idx,
    input  logic [7:0]              cmd_data,
    output logic                    cmd_done,
    output logic                    cmd_err,
    output logic [N_FIELDS*8-1:0]   fields,
    output logic [N_FIELDS-1:0]     dirty,
    input  logic                    clr_dirty
);

    typedef enum logic {IDLE, EXEC} state_e;

    state_e              state, state_nxt;
    bcd_op_e             lat_op;
    logic [IDX_W-1:0]    lat_idx;
    logic [7:0]          lat_data;
    logic [7:0]          fld [N_FIELDS];

    logic [7:0]          cur, lo, hi, step_res, load_cand, new_val;
    logic                idx_ok, is_load, load_ok, cmd_ok;
    logic                latch_en, wr_en, done_nxt, err_nxt;
    logic [N_FIELDS-1:0] set_mask;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        latch_en  = 1'b0;
        wr_en     = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    latch_en  = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
                err_nxt   = !cmd_ok;
                wr_en     = cmd_ok;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Select current value and limits of the addressed field.
    always_comb begin
        cur = '0;
        lo  = '0;
        hi  = '0;
        for (int i = 0; i < N_FIELDS; i++) begin
            if (lat_idx == IDX_W'(i)) begin
                cur = fld[i];
                lo  = FIELD_MIN[8*i +: 8];
                hi  = FIELD_MAX[8*i +: 8];
            end
        end
    end

    bcd_step u_step (
        .val (cur),
        .lo  (lo),
        .hi  (hi),
        .dec (lat_op == OP_DEC),
        .res (step_res)
    );

    always_comb begin
        idx_ok    = ({1'b0, lat_idx} < (IDX_W+1)'(N_FIELDS));
        is_load   = (lat_op == OP_LOAD_BYTE) || (lat_op == OP_LOAD_UNITS);
        load_cand = (lat_op == OP_LOAD_BYTE) ? lat_data : {cur[7:4], lat_data[3:0]};
        load_ok   = (load_cand[7:4] <= 4'd9) && (load_cand[3:0] <= 4'd9) &&
                    (load_cand >= lo) && (load_cand <= hi);
        cmd_ok    = idx_ok && (!is_load || load_ok);
        new_val   = is_load ? load_cand : step_res;
    end

    always_comb begin
        set_mask = '0;
        for (int i = 0; i < N_FIELDS; i++) begin
            if (wr_en && (lat_idx == IDX_W'(i)))
                set_mask[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_op   <= OP_LOAD_BYTE;
            lat_idx  <= '0;
            lat_data <= '0;
            cmd_done <= 1'b0;
            cmd_err  <= 1'b0;
            dirty    <= '0;
            for (int i = 0; i < N_FIELDS; i++)
                fld[i] <= FIELD_MIN[8*i +: 8];
        end else begin
            cmd_done <= done_nxt;
            cmd_err  <= err_nxt;
            if (latch_en) begin
                lat_op   <= bcd_op_e'(cmd_op);
                lat_idx  <= cmd_idx;
                lat_data <= cmd_data;
            end
            for (int i = 0; i < N_FIELDS; i++) begin
                if (set_mask[i])
                    fld[i] <= new_val;
            end
            // A set on the same edge as a clear wins.
            dirty <= (clr_dirty ? '0 : dirty) | set_mask;
        end
    end

    always_comb begin
        fields = '0;
        for (int i = 0; i < N_FIELDS; i++)
            fields[8*i +: 8] = fld[i];
    end

endmodule

// File: tb/tb_bcd_field_bank.sv
// Self-checking bench for bcd_field_bank: directed scenarios plus random
// commands compared against a decimal reference model.
module tb_bcd_field_bank;
    import bcd_pkg::*;

    localparam int N = 9;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [3:0]   cmd_idx;
    logic [7:0]   cmd_data;
    logic         cmd_done;
    logic         cmd_err;
    logic [71:0]  fields;
    logic [8:0]   dirty;
    logic         clr_dirty;

    int passed = 0;
    int total  = 0;

    // Reference model holds plain decimal values per field.
    int       m  [N];
    logic [N-1:0] md;
    int       mx [N] = '{23, 59, 59, 12, 31, 99, 23, 59, 59};
    int       mn [N] = '{0, 0, 0, 1, 1, 0, 0, 0, 0};

    bcd_field_bank dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_idx   (cmd_idx),
        .cmd_data  (cmd_data),
        .cmd_done  (cmd_done),
        .cmd_err   (cmd_err),
        .fields    (fields),
        .dirty     (dirty),
        .clr_dirty (clr_dirty)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < N; i++) m[i] = mn[i];
        md = '0;
    endfunction

    function automatic logic [71:0] exp_fields();
        logic [71:0] r = '0;
        for (int i = 0; i < N; i++) r[8*i +: 8] = 8'(((m[i] / 10) << 4) | (m[i] % 10));
        return r;
    endfunction

    // Applies one command to the model, returns expected error flag.
    function automatic logic model_cmd(input logic [1:0] op, input int idx,
                                       input logic [7:0] data, input logic clr);
        int t, u, v;
        if (clr) md = '0;
        if (idx >= N) return 1'b1;
        case (op)
            2'b00, 2'b01: begin
                t = (op == 2'b00) ? int'(data[7:4]) : m[idx] / 10;
                u = int'(data[3:0]);
                v = t * 10 + u;
                if (t > 9 || u > 9 || v < mn[idx] || v > mx[idx]) return 1'b1;
                m[idx] = v;
            end
            2'b10:   m[idx] = (m[idx] == mx[idx]) ? mn[idx] : m[idx] + 1;
            default: m[idx] = (m[idx] == mn[idx]) ? mx[idx] : m[idx] - 1;
        endcase
        md[idx] = 1'b1;
        return 1'b0;
    endfunction

    // Called at a negedge while the bank is idle; returns at the negedge
    // where cmd_done is seen, or after a bounded wait.
    task automatic issue(input logic [1:0] op, input logic [3:0] idx, input logic [7:0] data,
                         input logic clr, output logic got_done, output logic got_err);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_idx   = idx;
        cmd_data  = data;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_idx   = 4'($urandom);
        cmd_data  = 8'($urandom);
        clr_dirty = clr;
        got_done  = 1'b0;
        got_err   = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            clr_dirty = 1'b0;
            if (cmd_done) begin
                got_done = 1'b1;
                got_err  = cmd_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; clr_dirty = 1'b0;
        cmd_op = '0; cmd_idx = '0; cmd_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        total++; if (fields !== exp_fields()) $display("FAIL reset_fields: got %h exp %h", fields, exp_fields()); else passed++;
        total++; if (fields[39:24] !== 16'h0101) $display("FAIL reset_month_day: got %h exp 0101", fields[39:24]); else passed++;
        total++; if (dirty !== 9'd0) $display("FAIL reset_dirty: got %b exp 0", dirty); else passed++;
        total++; if (cmd_ready !== 1'b1 || cmd_done !== 1'b0) $display("FAIL reset_ready_done: got ready=%b done=%b exp 1/0", cmd_ready, cmd_done); else passed++;
        @(negedge clk);
    endtask

    task automatic test_load_byte();
        logic d, e, x;
        x = model_cmd(2'b00, 0, 8'h23, 1'b0);
        issue(2'b00, 4'd0, 8'h23, 1'b0, d, e);
        total++; if (d !== 1'b1 || e !== x || e !== 1'b0) $display("FAIL load23_done_err: got done=%b err=%b exp 1/0", d, e); else passed++;
        total++; if (fields[7:0] !== 8'h23 || dirty[0] !== 1'b1) $display("FAIL load23_value: got %h dirty0=%b exp 23/1", fields[7:0], dirty[0]); else passed++;
        x = model_cmd(2'b00, 0, 8'h24, 1'b0);
        issue(2'b00, 4'd0, 8'h24, 1'b0, d, e);
        total++; if (d !== 1'b1 || e !== x || e !== 1'b1) $display("FAIL load24_reject: got done=%b err=%b exp 1/1", d, e); else passed++;
        total++; if (fields !== exp_fields()) $display("FAIL load24_fields: got %h exp %h", fields, exp_fields()); else passed++;
    endtask

    task automatic test_inc_dec();
        logic d, e, x;
        x = model_cmd(2'b00, 2, 8'h59, 1'b0); issue(2'b00, 4'd2, 8'h59, 1'b0, d, e);
        x = model_cmd(2'b10, 2, 8'h00, 1'b0); issue(2'b10, 4'd2, 8'h00, 1'b0, d, e);
        total++; if (d !== 1'b1 || e !== x || fields[23:16] !== 8'h00) $display("FAIL inc_sec_wrap: got done=%b err=%b sec=%h exp 1/0/00", d, e, fields[23:16]); else passed++;
        x = model_cmd(2'b11, 3, 8'h00, 1'b0); issue(2'b11, 4'd3, 8'h00, 1'b0, d, e);
        total++; if (d !== 1'b1 || e !== x || fields[31:24] !== 8'h12) $display("FAIL dec_month_wrap: got done=%b err=%b month=%h exp 1/0/12", d, e, fields[31:24]); else passed++;
        x = model_cmd(2'b00, 1, 8'h09, 1'b0); issue(2'b00, 4'd1, 8'h09, 1'b0, d, e);
        x = model_cmd(2'b10, 1, 8'h00, 1'b0); issue(2'b10, 4'd1, 8'h00, 1'b0, d, e);
        total++; if (d !== 1'b1 || e !== x || fields[15:8] !== 8'h10) $display("FAIL inc_min_carry: got done=%b err=%b min=%h exp 1/0/10", d, e, fields[15:8]); else passed++;
        x = model_cmd(2'b11, 1, 8'h00, 1'b0); issue(2'b11, 4'd1, 8'h00, 1'b0, d, e);
        total++; if (fields[15:8] !== 8'h09 || fields !== exp_fields()) $display("FAIL dec_min_borrow: got %h exp 09", fields[15:8]); else passed++;
    endtask

    task automatic test_load_units();
        logic d, e, x;
        x = model_cmd(2'b01, 1, 8'h0A, 1'b0); issue(2'b01, 4'd1, 8'h0A, 1'b0, d, e);
        total++; if (d !== 1'b1 || e !== 1'b1 || e !== x) $display("FAIL units_A_reject: got done=%b err=%b exp 1/1", d, e); else passed++;
        x = model_cmd(2'b00, 1, 8'h40, 1'b0); issue(2'b00, 4'd1, 8'h40, 1'b0, d, e);
        x = model_cmd(2'b01, 1, 8'hF7, 1'b0); issue(2'b01, 4'd1, 8'hF7, 1'b0, d, e);
        total++; if (d !== 1'b1 || e !== x || fields[15:8] !== 8'h47) $display("FAIL units_7: got err=%b min=%h exp 0/47", e, fields[15:8]); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [1:0] op;
        logic [3:0] idx;
        logic [7:0] data;
        logic       x;
        int         v;
        cmd_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            op  = (k == 0) ? 2'b10 : 2'($urandom_range(0, 3));
            idx = (k == 0) ? 4'd9 : 4'($urandom_range(0, 8));
            v   = $urandom_range(0, 99);
            data = 8'(((v / 10) << 4) | (v % 10));
            cmd_op = op; cmd_idx = idx; cmd_data = data;
            x = model_cmd(op, int'(idx), data, 1'b0);
            total++; if (cmd_ready !== 1'b1) $display("FAIL b2b_ready_accept[%0d]: got %b exp 1", k, cmd_ready); else passed++;
            @(negedge clk);
            total++; if (cmd_ready !== 1'b0 || cmd_done !== 1'b0 || cmd_err !== 1'b0) $display("FAIL b2b_exec[%0d]: got ready=%b done=%b err=%b exp 0/0/0", k, cmd_ready, cmd_done, cmd_err); else passed++;
            cmd_op = 2'($urandom); cmd_idx = 4'($urandom); cmd_data = 8'($urandom);
            @(negedge clk);
            total++; if (cmd_done !== 1'b1 || cmd_err !== x) $display("FAIL b2b_done[%0d]: got done=%b err=%b exp 1/%b", k, cmd_done, cmd_err, x); else passed++;
            total++; if (fields !== exp_fields()) $display("FAIL b2b_fields[%0d]: got %h exp %h", k, fields, exp_fields()); else passed++;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset_abort();
        logic d, e, x;
        x = model_cmd(2'b00, 4, 8'h05, 1'b0); issue(2'b00, 4'd4, 8'h05, 1'b0, d, e);
        total++; if (fields[39:32] !== 8'h05 || e !== x) $display("FAIL abort_setup_day: got %h exp 05", fields[39:32]); else passed++;
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_idx = 4'd4; cmd_data = 8'h00;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        total++; if (cmd_done !== 1'b0) $display("FAIL abort_no_done: got %b exp 0", cmd_done); else passed++;
        total++; if (fields[39:32] !== 8'h01 || fields !== exp_fields() || dirty !== 9'd0) $display("FAIL abort_state: got day=%h dirty=%b exp 01/0", fields[39:32], dirty); else passed++;
        @(negedge clk);
        total++; if (cmd_done !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL abort_after: got done=%b ready=%b exp 0/1", cmd_done, cmd_ready); else passed++;
        x = model_cmd(2'b00, 0, 8'h10, 1'b0); issue(2'b00, 4'd0, 8'h10, 1'b0, d, e);
        x = model_cmd(2'b00, 2, 8'h30, 1'b1); issue(2'b00, 4'd2, 8'h30, 1'b1, d, e);
        total++; if (dirty !== 9'b000000100 || dirty !== md) $display("FAIL clr_same_edge: got %b exp 000000100", dirty); else passed++;
    endtask

    task automatic test_random();
        logic [1:0] op;
        logic [3:0] idx;
        logic [7:0] data;
        logic       clr, d, e, x;
        int         v;
        for (int k = 0; k < 60; k++) begin
            op  = 2'($urandom_range(0, 3));
            idx = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            if ($urandom_range(0, 4) == 0) data = 8'($urandom);
            else begin
                v = $urandom_range(0, 99);
                data = 8'(((v / 10) << 4) | (v % 10));
            end
            clr = ($urandom_range(0, 5) == 0);
            x = model_cmd(op, int'(idx), data, clr);
            issue(op, idx, data, clr, d, e);
            total++; if (d !== 1'b1 || e !== x) $display("FAIL rand_done_err[%0d]: got done=%b err=%b exp 1/%b", k, d, e, x); else passed++;
            total++; if (fields !== exp_fields()) $display("FAIL rand_fields[%0d]: got %h exp %h", k, fields, exp_fields()); else passed++;
            total++; if (dirty !== md) $display("FAIL rand_dirty[%0d]: got %b exp %b", k, dirty, md); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_inc_dec();
        test_load_units();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
